// File: rtl/rotate_cmd_issuer_pkg.sv
// Shared definitions for the rotate command issuer: field widths, opcodes, FSM states.
package rotate_cmd_issuer_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 16;
    localparam int CMD_W  = OP_W + DATA_W;

    localparam logic [OP_W-1:0] OP_ROTATE = 4'd10;
    localparam logic [OP_W-1:0] OP_IDLE   = 4'd0;

    // Encodings kept identical to the legacy localparam values.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Queued command word: opcode in the top bits, operand below.
    function automatic logic [CMD_W-1:0] pack_cmd(input logic [OP_W-1:0]   op,
                                                   input logic [DATA_W-1:0] data);
        return {op, data};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), registered count, full/empty from count.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count holds on simultaneous push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rotate_cmd_issuer.sv
// Rotate command issuer: queues host commands and issues them one at a time to the
// rotate stage, waiting for completion (or timeout) and inserting an idle gap between issues.
module rotate_cmd_issuer
    import rotate_cmd_issuer_pkg::*;
#(
    parameter int              DEPTH        = 4,
    parameter logic [OP_W-1:0] IDLE_OPCODE  = OP_IDLE,
    parameter int              DONE_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OP_W-1:0]        cmd_opcode,
    input  logic [DATA_W-1:0]      cmd_data,
    output logic [OP_W-1:0]        exe_opcode,
    output logic [DATA_W-1:0]      exe_data,
    output logic                   exe_start,
    input  logic                   exe_done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   timeout_err,
    input  logic                   err_clear
);

    localparam int             TW       = $clog2(DONE_TIMEOUT) + 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(DONE_TIMEOUT - 1);

    state_t           state;
    logic [TW-1:0]    tmo_cnt;
    logic [CMD_W-1:0] head;
    logic [OP_W-1:0]  head_op;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign head_op   = head[CMD_W-1 -: OP_W];

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (pack_cmd(cmd_opcode, cmd_data)),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue FSM, timeout counter and registered exe outputs.
    // err_clear is applied first so a same-cycle timeout assignment below overrides it.
    // exe_done is ignored while exe_start is high (the first WAIT cycle).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            exe_opcode  <= IDLE_OPCODE;
            exe_data    <= '0;
            exe_start   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            exe_start <= 1'b0;
            if (err_clear) timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && head_op != IDLE_OPCODE) begin
                        exe_opcode <= head_op;
                        exe_data   <= head[DATA_W-1:0];
                        exe_start  <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (exe_done && !exe_start) begin
                        exe_opcode <= IDLE_OPCODE;
                        state      <= ST_GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        exe_opcode  <= IDLE_OPCODE;
                        state       <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_cmd_issuer.sv
// Directed self-checking bench for rotate_cmd_issuer.
module tb_rotate_cmd_issuer;
    import rotate_cmd_issuer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = 4'd0;
    logic [15:0] cmd_data = 16'd0;
    logic [3:0]  exe_opcode;
    logic [15:0] exe_data;
    logic        exe_start;
    logic        exe_done = 1'b0;
    logic [2:0]  fifo_count;
    logic        timeout_err;
    logic        err_clear = 1'b0;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;

    rotate_cmd_issuer #(
        .DEPTH        (DEPTH),
        .IDLE_OPCODE  (OP_IDLE),
        .DONE_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_data    (cmd_data),
        .exe_opcode  (exe_opcode),
        .exe_data    (exe_data),
        .exe_start   (exe_start),
        .exe_done    (exe_done),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err),
        .err_clear   (err_clear)
    );

    always #5 clk = ~clk;

    // Count cycles in which exe_start was high.
    always @(posedge clk) begin
        if (exe_start) start_cnt <= start_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] d);
        cmd_valid  = v;
        cmd_opcode = op;
        cmd_data   = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        tests++; if (exe_opcode !== 4'd0) begin fails++; $display("FAIL reset_opcode got %0d exp 0", exe_opcode); end
        tests++; if (exe_data !== 16'h0) begin fails++; $display("FAIL reset_data got %0h exp 0", exe_data); end
        tests++; if (exe_start !== 1'b0) begin fails++; $display("FAIL reset_start got %0b exp 0", exe_start); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b exp 0", timeout_err); end
        reset = 1'b0;
        tick();
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b exp 1", cmd_ready); end
    endtask

    task automatic test_single_issue();
        drive(1'b1, OP_ROTATE, 16'h00F0);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL single_count got %0d exp 1", fifo_count); end
        tests++; if (exe_start !== 1'b0) begin fails++; $display("FAIL single_early_start got %0b exp 0", exe_start); end
        tick();
        tests++; if (exe_start !== 1'b1) begin fails++; $display("FAIL single_start got %0b exp 1", exe_start); end
        tests++; if (exe_opcode !== 4'd10) begin fails++; $display("FAIL single_opcode got %0d exp 10", exe_opcode); end
        tests++; if (exe_data !== 16'h00F0) begin fails++; $display("FAIL single_data got %0h exp 00f0", exe_data); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL single_popped got %0d exp 0", fifo_count); end
        tick();
        tests++; if (exe_start !== 1'b0) begin fails++; $display("FAIL single_pulse got %0b exp 0", exe_start); end
        repeat (3) tick();
        tests++; if (exe_opcode !== 4'd10) begin fails++; $display("FAIL single_hold_op got %0d exp 10", exe_opcode); end
        tests++; if (exe_data !== 16'h00F0) begin fails++; $display("FAIL single_hold_data got %0h exp 00f0", exe_data); end
        repeat (4) tick();
        exe_done = 1'b1;
        tick();
        exe_done = 1'b0;
        tests++; if (exe_opcode !== 4'd0) begin fails++; $display("FAIL single_gap_op got %0d exp 0", exe_opcode); end
        tests++; if (exe_data !== 16'h00F0) begin fails++; $display("FAIL single_gap_data got %0h exp 00f0", exe_data); end
        tick();
        tests++; if (exe_opcode !== 4'd0 || exe_start !== 1'b0) begin fails++; $display("FAIL single_idle got op=%0d start=%0b exp op=0 start=0", exe_opcode, exe_start); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL single_err got %0b exp 0", timeout_err); end
    endtask

    task automatic test_idle_opcode();
        int s0;
        s0 = start_cnt;
        drive(1'b1, OP_IDLE, 16'hABCD);
        tick();
        drive(1'b1, OP_ROTATE, 16'h1234);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        tests++; if (exe_start !== 1'b0) begin fails++; $display("FAIL idleop_start got %0b exp 0", exe_start); end
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL idleop_count got %0d exp 1", fifo_count); end
        tick();
        tests++; if (exe_start !== 1'b1 || exe_data !== 16'h1234 || exe_opcode !== 4'd10) begin fails++; $display("FAIL idleop_issue got start=%0b op=%0d data=%0h exp start=1 op=10 data=1234", exe_start, exe_opcode, exe_data); end
        tests++; if (start_cnt !== s0) begin fails++; $display("FAIL idleop_discard_starts got %0d exp %0d", start_cnt, s0); end
        exe_done = 1'b1;
        tick();
        exe_done = 1'b0;
        tests++; if (exe_opcode !== 4'd10) begin fails++; $display("FAIL done_in_start_cycle got %0d exp 10", exe_opcode); end
        exe_done = 1'b1;
        tick();
        exe_done = 1'b0;
        tests++; if (exe_opcode !== 4'd0) begin fails++; $display("FAIL idleop_gap got %0d exp 0", exe_opcode); end
        tick();
        exe_done = 1'b1;
        tick();
        exe_done = 1'b0;
        tick();
        tests++; if (exe_opcode !== 4'd0 || start_cnt !== s0 + 1) begin fails++; $display("FAIL done_outside_wait got op=%0d starts=%0d exp op=0 starts=%0d", exe_opcode, start_cnt, s0 + 1); end
    endtask

    task automatic test_fifo_full();
        logic [15:0] q [5];
        for (int i = 0; i < 5; i++) q[i] = 16'hA001 + 16'(i);
        drive(1'b1, OP_ROTATE, 16'h1111);
        tick();
        drive(1'b1, OP_ROTATE, q[0]);
        tick();
        tests++; if (exe_start !== 1'b1 || fifo_count !== 3'd1) begin fails++; $display("FAIL full_pushpop got start=%0b count=%0d exp start=1 count=1", exe_start, fifo_count); end
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, OP_ROTATE, q[i]);
            tick();
        end
        tests++; if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin fails++; $display("FAIL full_after4 got ready=%0b count=%0d exp ready=0 count=4", cmd_ready, fifo_count); end
        drive(1'b1, OP_ROTATE, q[4]);
        tick();
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_stall got %0d exp 4", fifo_count); end
        exe_done = 1'b1;
        tick();
        exe_done = 1'b0;
        tick();
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL full_ready_pop_cycle got %0b exp 0", cmd_ready); end
        tick();
        tests++; if (exe_start !== 1'b1 || exe_data !== q[0] || fifo_count !== 3'd3 || cmd_ready !== 1'b1) begin fails++; $display("FAIL full_first_pop got start=%0b data=%0h count=%0d ready=%0b exp 1 %0h 3 1", exe_start, exe_data, fifo_count, cmd_ready, q[0]); end
        tick();
        drive(1'b0, 4'd0, 16'h0);
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_fifth_in got %0d exp 4", fifo_count); end
        for (int i = 1; i < 5; i++) begin
            exe_done = 1'b1;
            tick();
            exe_done = 1'b0;
            tests++; if (exe_opcode !== 4'd0) begin fails++; $display("FAIL full_gap%0d got %0d exp 0", i, exe_opcode); end
            tick();
            tick();
            tests++; if (exe_start !== 1'b1 || exe_data !== q[i]) begin fails++; $display("FAIL full_order%0d got start=%0b data=%0h exp start=1 data=%0h", i, exe_start, exe_data, q[i]); end
            tick();
        end
        exe_done = 1'b1;
        tick();
        exe_done = 1'b0;
        tick();
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL full_drained got %0d exp 0", fifo_count); end
    endtask

    task automatic test_timeout();
        drive(1'b1, OP_ROTATE, 16'h7777);
        tick();
        drive(1'b1, OP_ROTATE, 16'h8888);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        tests++; if (exe_start !== 1'b1 || fifo_count !== 3'd1) begin fails++; $display("FAIL tmo_issue got start=%0b count=%0d exp 1 1", exe_start, fifo_count); end
        repeat (15) tick();
        tests++; if (timeout_err !== 1'b0 || exe_opcode !== 4'd10) begin fails++; $display("FAIL tmo_early got err=%0b op=%0d exp err=0 op=10", timeout_err, exe_opcode); end
        tick();
        tests++; if (timeout_err !== 1'b1 || exe_opcode !== 4'd0 || exe_data !== 16'h7777) begin fails++; $display("FAIL tmo_fire got err=%0b op=%0d data=%0h exp 1 0 7777", timeout_err, exe_opcode, exe_data); end
        tick();
        tick();
        tests++; if (exe_start !== 1'b1 || exe_data !== 16'h8888 || timeout_err !== 1'b1) begin fails++; $display("FAIL tmo_next got start=%0b data=%0h err=%0b exp 1 8888 1", exe_start, exe_data, timeout_err); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL tmo_clear got %0b exp 0", timeout_err); end
        exe_done = 1'b1;
        tick();
        exe_done = 1'b0;
        tick();
        drive(1'b1, OP_ROTATE, 16'h9999);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        tick();
        err_clear = 1'b1;
        repeat (15) tick();
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL tmo2_early got %0b exp 0", timeout_err); end
        tick();
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL tmo_set_wins got %0b exp 1", timeout_err); end
        err_clear = 1'b0;
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL tmo2_clear got %0b exp 0", timeout_err); end
    endtask

    task automatic test_wrap();
        logic [15:0] qd [4];
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) qd[i] = 16'((r + 1) << 8) | 16'(i);
            drive(1'b1, OP_ROTATE, 16'hF000 | 16'(r));
            tick();
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, OP_ROTATE, qd[i]);
                tick();
            end
            tests++; if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin fails++; $display("FAIL wrap%0d_full got ready=%0b count=%0d exp 0 4", r, cmd_ready, fifo_count); end
            drive(1'b1, OP_ROTATE, 16'hDEAD);
            exe_done = 1'b1;
            tick();
            exe_done = 1'b0;
            tick();
            tick();
            drive(1'b0, 4'd0, 16'h0);
            tests++; if (fifo_count !== 3'd3 || exe_data !== qd[0] || cmd_ready !== 1'b1) begin fails++; $display("FAIL wrap%0d_refuse got count=%0d data=%0h ready=%0b exp 3 %0h 1", r, fifo_count, exe_data, cmd_ready, qd[0]); end
            tick();
            for (int i = 1; i < 4; i++) begin
                exe_done = 1'b1;
                tick();
                exe_done = 1'b0;
                tick();
                tick();
                tests++; if (exe_start !== 1'b1 || exe_data !== qd[i]) begin fails++; $display("FAIL wrap%0d_order%0d got start=%0b data=%0h exp 1 %0h", r, i, exe_start, exe_data, qd[i]); end
                tick();
            end
            exe_done = 1'b1;
            tick();
            exe_done = 1'b0;
            tick();
            tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL wrap%0d_empty got %0d exp 0", r, fifo_count); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int s0;
        drive(1'b1, OP_ROTATE, 16'h0101);
        tick();
        drive(1'b1, OP_ROTATE, 16'h0202);
        tick();
        drive(1'b1, OP_ROTATE, 16'h0303);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        tests++; if (fifo_count !== 3'd2 || exe_opcode !== 4'd10) begin fails++; $display("FAIL rst_setup got count=%0d op=%0d exp 2 10", fifo_count, exe_opcode); end
        reset = 1'b1;
        #1;
        tests++; if (fifo_count !== 3'd0 || exe_opcode !== 4'd0 || exe_data !== 16'h0) begin fails++; $display("FAIL rst_async got count=%0d op=%0d data=%0h exp 0 0 0", fifo_count, exe_opcode, exe_data); end
        tick();
        reset = 1'b0;
        s0 = start_cnt;
        repeat (6) tick();
        tests++; if (start_cnt !== s0 || exe_start !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_quiet got starts=%0d count=%0d ready=%0b exp %0d 0 1", start_cnt, fifo_count, cmd_ready, s0); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_idle_opcode();
        test_fifo_full();
        test_timeout();
        test_wrap();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rotate_cmd_issuer.md
ROTATE_CMD_ISSUER -- requirements
Module: rotate_cmd_issuer

Interface
REQ-001 Parameter DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter IDLE_OPCODE, 4'd0, opcode driven when no command is in flight.
REQ-003 Parameter DONE_TIMEOUT, 16, maximum cycles spent in WAIT before abort.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 cmd_valid  in  1  host offers a command.
REQ-007 cmd_ready  out  1  FIFO can accept; transfer when cmd_valid & cmd_ready.
REQ-008 cmd_opcode  in  4  command opcode (10 = rotate).
REQ-009 cmd_data  in  16  command operand.
REQ-010 exe_opcode  out  4  opcode to the rotate stage, registered.
REQ-011 exe_data  out  16  operand to the rotate stage, registered.
REQ-012 exe_start  out  1  one-cycle pulse marking a new issue.
REQ-013 exe_done  in  1  one-cycle pulse from the rotate stage, operation complete.
REQ-014 fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 timeout_err  out  1  sticky, set on WAIT timeout.
REQ-016 err_clear  in  1  synchronous clear of timeout_err.

Function
REQ-017 The block SHALL buffer commands in a DEPTH-entry FIFO, first in first out.
REQ-018 cmd_ready SHALL equal (fifo_count != DEPTH), from registered count only; a same-cycle pop SHALL NOT raise it.
REQ-019 Simultaneous push and pop SHALL leave fifo_count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-020 The FSM SHALL have states IDLE, WAIT, GAP.
REQ-021 IDLE, fifo_count>0, head opcode != IDLE_OPCODE: next edge pops head, loads exe_opcode/exe_data, pulses exe_start for exactly one cycle, enters WAIT, zeroes timeout counter.
REQ-022 IDLE, head opcode == IDLE_OPCODE: next edge pops and discards it, stays IDLE, no exe_start.
REQ-023 WAIT: exe_opcode/exe_data SHALL hold stable; exe_done is sampled only from the cycle after exe_start.
REQ-024 WAIT with exe_done=1: next edge drives exe_opcode to IDLE_OPCODE and enters GAP.
REQ-025 WAIT without exe_done for DONE_TIMEOUT consecutive cycles: next edge sets timeout_err, drives exe_opcode to IDLE_OPCODE, enters GAP.
REQ-026 GAP SHALL last exactly one cycle with exe_opcode=IDLE_OPCODE, then IDLE; guarantees an opcode change between back-to-back commands.
REQ-027 exe_done outside WAIT SHALL be ignored.
REQ-028 timeout set and err_clear in the same cycle: set wins.
REQ-029 Minimum issue-to-issue spacing SHALL be 4 cycles (start, >=1 WAIT, done edge, GAP).
REQ-030 exe_data SHALL retain its last value outside WAIT; only exe_opcode returns to idle.

Reset
REQ-031 reset SHALL asynchronously force: state IDLE, FIFO empty (pointers 0, fifo_count 0), exe_opcode=IDLE_OPCODE, exe_data=0, exe_start=0, timeout_err=0, timeout counter 0.
REQ-032 reset mid-WAIT SHALL drop the in-flight command and all buffered commands; no exe_start until a new push after reset release.
REQ-033 cmd_ready SHALL read 1 in the first cycle after reset deasserts.

Structure
REQ-034 Shared package SHALL hold the opcode width (4), data width (16), OP_ROTATE=4'd10, OP_IDLE=4'd0 and the FSM state enum.
REQ-035 The FIFO SHALL be one sub-module, cmd_fifo (parameterised DEPTH, width 20, push/pop/count/full/empty).
REQ-036 FSM, timeout counter and exe output registers SHALL live in rotate_cmd_issuer.

Verification
REQ-037 Push {10,16'h00F0} into empty FIFO at edge k -> exe_start high after edge k+1, exe_opcode=10, exe_data=16'h00F0; done 8 cycles later -> exe_opcode=0 next cycle, GAP one cycle.
REQ-038 Push 5 commands back-to-back with exe_done held 0 -> cmd_ready=0 after 4th accepted while first still queued (count=4), 5th stalls until first pop, order preserved.
REQ-039 Issue, never assert exe_done -> after 16 WAIT cycles timeout_err=1, exe_opcode=0, next queued command issues; err_clear -> timeout_err=0.
REQ-040 Push {0,16'hABCD} then {10,16'h1234} -> first discarded without exe_start, second issued with exe_data=16'h1234.
REQ-041 Assert reset for one cycle during WAIT with 2 commands queued -> fifo_count=0, exe_opcode=0, no exe_start afterwards without new push.
REQ-042 Push while full and popping in same cycle -> push refused (cmd_ready=0), count decrements to DEPTH-1, pointers wrap correctly over 3 full cycles of traffic.
